// File: rtl/shift_out_pkg.sv
// Shared types and helpers for the parallel-in, serial-out transmitter.
// Provides the FSM state type and the bit counter width helper.
package shift_out_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } so_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Down counter for the bits remaining in a word.
// flush beats load, load beats dec, and dec saturates at zero.
module bit_down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         flush,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/shift_out_register.sv
// Parallel-in, serial-out transmitter with valid/ready on both sides.
// The last beat of a word can overlap the load of the next one.
module shift_out_register
  import shift_out_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic [N-1:0] in,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         abort,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_last,
  input  logic         ser_ready,
  output logic         busy
);

  localparam int W = cnt_w(N);
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  so_state_t      state;
  logic [N-1:0]   shreg;
  logic [W-1:0]   cnt;
  logic           zero;
  logic           load_fire;
  logic           beat_fire;
  logic           in_shift;

  assign in_shift  = (state == SHIFT);
  assign ser_valid = in_shift;
  assign ser_last  = in_shift & zero;
  assign busy      = in_shift;
  assign ser_out   = MSB_FIRST ? shreg[N-1] : shreg[0];

  // Reload is allowed while the final bit is being accepted.
  assign load_ready = !abort &
                      (!in_shift | (zero & ser_ready));
  assign load_fire  = load_valid & load_ready;
  assign beat_fire  = ser_valid & ser_ready;

  bit_down_counter #(
    .W (W)
  ) u_cnt (
    .clk      (clk),
    .clear_n  (clear_n),
    .load     (load_fire),
    .load_val (LAST_IDX),
    .dec      (beat_fire),
    .flush    (abort),
    .cnt      (cnt),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      shreg <= '0;
    end else if (abort) begin
      state <= IDLE;
      shreg <= '0;
    end else if (load_fire) begin
      state <= SHIFT;
      shreg <= in;
    end else if (beat_fire) begin
      shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      if (zero) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_shift_out_register.sv
// Bench for shift_out_register: MSB- and LSB-first copies driven in
// lockstep and compared against a queue-of-bits reference model.
module tb_shift_out_register;

  localparam int N = 8;

  logic         clk;
  logic         clear_n;
  logic [N-1:0] din;
  logic         load_valid;
  logic         abort;
  logic         ser_ready;

  logic m_load_ready, m_ser_out, m_ser_valid, m_ser_last, m_busy;
  logic l_load_ready, l_ser_out, l_ser_valid, l_ser_last, l_busy;

  shift_out_register #(.N(N), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .clear_n    (clear_n),
    .in         (din),
    .load_valid (load_valid),
    .load_ready (m_load_ready),
    .abort      (abort),
    .ser_out    (m_ser_out),
    .ser_valid  (m_ser_valid),
    .ser_last   (m_ser_last),
    .ser_ready  (ser_ready),
    .busy       (m_busy)
  );

  shift_out_register #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .clear_n    (clear_n),
    .in         (din),
    .load_valid (load_valid),
    .load_ready (l_load_ready),
    .abort      (abort),
    .ser_out    (l_ser_out),
    .ser_valid  (l_ser_valid),
    .ser_last   (l_ser_last),
    .ser_ready  (ser_ready),
    .busy       (l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  bit qm[$];
  bit ql[$];
  logic [N-1:0] rxm;
  logic [N-1:0] rxl;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_word(input string tag, input logic [N-1:0] obs,
                          input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Compare both copies against the model for the current inputs.
  task automatic check_outputs(input string tag);
    logic v;
    logic lr;
    v  = (qm.size() > 0);
    lr = !abort && (qm.size() == 0 || (qm.size() == 1 && ser_ready));
    chk({tag, " m_valid"}, m_ser_valid, v);
    chk({tag, " m_busy"},  m_busy,      v);
    chk({tag, " m_last"},  m_ser_last,  v && qm.size() == 1);
    chk({tag, " m_out"},   m_ser_out,   v ? qm[0] : 1'b0);
    chk({tag, " m_lrdy"},  m_load_ready, lr);
    chk({tag, " l_valid"}, l_ser_valid, v);
    chk({tag, " l_busy"},  l_busy,      v);
    chk({tag, " l_last"},  l_ser_last,  v && ql.size() == 1);
    chk({tag, " l_out"},   l_ser_out,   v ? ql[0] : 1'b0);
    chk({tag, " l_lrdy"},  l_load_ready, lr);
  endtask

  // One clock: drive after negedge, check, take the edge, update model.
  task automatic step(input string tag, input logic lv,
                      input logic [N-1:0] w, input logic sr,
                      input logic ab);
    logic v;
    logic lr;
    load_valid = lv;
    din        = w;
    ser_ready  = sr;
    abort      = ab;
    #1;
    check_outputs(tag);
    v  = (qm.size() > 0);
    lr = !ab && (qm.size() == 0 || (qm.size() == 1 && sr));
    if (v && sr) begin
      rxm = {rxm[N-2:0], m_ser_out};
      rxl = {l_ser_out, rxl[N-1:1]};
    end
    @(posedge clk);
    if (ab) begin
      qm.delete();
      ql.delete();
    end else begin
      if (v && sr) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (lv && lr) begin
        for (int i = 0; i < N; i++) begin
          qm.push_back(w[N-1-i]);
          ql.push_back(w[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [3:0] pat;
    clear_n    = 1'b0;
    din        = '0;
    load_valid = 1'b0;
    abort      = 1'b0;
    ser_ready  = 1'b0;
    rxm        = '0;
    rxl        = '0;
    @(negedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    step("rst_idle", 1'b0, '0, 1'b0, 1'b0);

    // Basic word in both bit orders.
    rxm = '0; rxl = '0;
    step("a5_load", 1'b1, 8'hA5, 1'b1, 1'b0);
    idle_steps("a5", 9);
    chk_word("a5_rx_msb", rxm, 8'hA5);
    chk_word("a5_rx_lsb", rxl, 8'hA5);

    rxm = '0; rxl = '0;
    step("01_load", 1'b1, 8'h01, 1'b1, 1'b0);
    idle_steps("01", 9);
    chk_word("01_rx_msb", rxm, 8'h01);
    chk_word("01_rx_lsb", rxl, 8'h01);

    // Back-pressure with ready pattern 1,0,0,1.
    rxm = '0; rxl = '0;
    pat = 4'b1001;
    step("c3_load", 1'b1, 8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++)
      step("bp", 1'b0, 8'h00, pat[3 - (i % 4)], 1'b0);
    idle_steps("bp_tail", 2);
    chk_word("c3_rx_msb", rxm, 8'hC3);
    chk_word("c3_rx_lsb", rxl, 8'hC3);

    // Back-to-back words with load_valid held.
    step("b2b_load", 1'b1, 8'hF0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step("b2b_w1", 1'b1, 8'h0F, 1'b1, 1'b0);
    rxm = '0;
    idle_steps("b2b_w2", 9);
    chk_word("b2b_rx2", rxm, 8'h0F);

    // Abort after three beats with a competing load.
    step("ab_load", 1'b1, 8'hFF, 1'b1, 1'b0);
    idle_steps("ab_beats", 3);
    step("ab_fire", 1'b1, 8'h55, 1'b1, 1'b1);
    idle_steps("ab_after", 2);
    rxm = '0; rxl = '0;
    step("81_load", 1'b1, 8'h81, 1'b1, 1'b0);
    idle_steps("81", 9);
    chk_word("81_rx_msb", rxm, 8'h81);
    chk_word("81_rx_lsb", rxl, 8'h81);

    // Asynchronous reset in the middle of a word.
    step("rst_load", 1'b1, 8'h3C, 1'b1, 1'b0);
    idle_steps("rst_mid", 2);
    load_valid = 1'b0;
    abort      = 1'b0;
    #2;
    clear_n = 1'b0;
    #1;
    chk("arst m_valid", m_ser_valid, 1'b0);
    chk("arst m_last",  m_ser_last,  1'b0);
    chk("arst m_out",   m_ser_out,   1'b0);
    chk("arst m_busy",  m_busy,      1'b0);
    chk("arst m_lrdy",  m_load_ready, 1'b1);
    chk("arst l_valid", l_ser_valid, 1'b0);
    chk("arst l_busy",  l_busy,      1'b0);
    qm.delete();
    ql.delete();
    @(negedge clk);
    clear_n = 1'b1;
    idle_steps("post_rst", 3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           1'($urandom_range(0, 3) != 0),
           N'($urandom),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 19) == 0));
    end
    idle_steps("drain", 12);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
